cop_perfcnt: RTL

COP_PERFCNT -- requirements
Module: cop_perfcnt

---
 rtl/cop_perfcnt.sv | 117 +++++++++++
 1 files changed

// File: rtl/cop_perfcnt.sv
// Performance counter bank: NCNT event counters with EN/IE/OVF/ESEL controls behind a 5-bit register port.
// Reads return data one cycle after CRDGEN; no backpressure. COP_PERFCNT_OVFINT_EN compiles in IE and PERF_INT_R.
module cop_perfcnt #(
  parameter int NCNT  = 4,
  parameter int CNT_W = 32,
  parameter int NEV   = 8
) (
  input  logic            SYSCLK,
  input  logic            RESET_D1_R_N,
  input  logic [NEV-1:0]  EVENTS,
  input  logic            HALT,
  input  logic [4:0]      CRDADDR,
  input  logic            CRDGEN,
  output logic [31:0]     CRDDATA_R,
  input  logic [4:0]      CWRADDR,
  input  logic            CWRGEN,
  input  logic [31:0]     CWRDATA,
  output logic            PERF_INT_R
);

  logic [NCNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCNT-1:0][3:0]       esel_q, esel_d;
  logic [NCNT-1:0]            en_q, en_d;
  logic [NCNT-1:0]            ie_q, ie_d;
  logic [NCNT-1:0]            ovf_q, ovf_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       perf_int_q, perf_int_d;

  logic [15:0]     ev_pad;
  logic [NCNT-1:0] cnt_wr, ctl_wr, inc, hw_ovf;
  logic [31:0]     rd_val;
  logic            unused_wdata;

  assign unused_wdata = ^{CWRDATA[31:8], CWRDATA[3]};

  always_comb begin
    // Unimplemented event lines read as 0, so ESEL >= NEV never counts.
    ev_pad = '0;
    ev_pad[NEV-1:0] = EVENTS;

    cnt_d   = cnt_q;
    esel_d  = esel_q;
    en_d    = en_q;
    ie_d    = ie_q;
    ovf_d   = ovf_q;
    cnt_wr  = '0;
    ctl_wr  = '0;
    inc     = '0;
    hw_ovf  = '0;
    rd_val  = '0;

    for (int i = 0; i < NCNT; i++) begin
      cnt_wr[i] = CWRGEN && (CWRADDR == 5'(2 * i));
      ctl_wr[i] = CWRGEN && (CWRADDR == 5'(2 * i + 1));
      inc[i]    = en_q[i] && !HALT && ev_pad[esel_q[i]];
      // A counter write drops the increment, including its wrap and OVF.
      hw_ovf[i] = inc[i] && !cnt_wr[i] && (&cnt_q[i]);

      if (cnt_wr[i]) begin
        cnt_d[i] = CWRDATA[CNT_W-1:0];
      end else if (inc[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      if (ctl_wr[i]) begin
        en_d[i]   = CWRDATA[0];
`ifdef COP_PERFCNT_OVFINT_EN
        ie_d[i]   = CWRDATA[1];
`else
        ie_d[i]   = 1'b0;
`endif
        ovf_d[i]  = CWRDATA[2] | hw_ovf[i];
        esel_d[i] = CWRDATA[7:4];
      end else if (hw_ovf[i]) begin
        ovf_d[i] = 1'b1;
      end

      if (CRDADDR == 5'(2 * i)) begin
        rd_val[CNT_W-1:0] = cnt_q[i];
      end else if (CRDADDR == 5'(2 * i + 1)) begin
        rd_val[7:0] = {esel_q[i], 1'b0, ovf_q[i], ie_q[i], en_q[i]};
      end
    end

    rdata_d = CRDGEN ? rd_val : rdata_q;

`ifdef COP_PERFCNT_OVFINT_EN
    perf_int_d = |(ovf_q & ie_q);
`else
    perf_int_d = 1'b0;
`endif
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_D1_R_N) begin
      cnt_q      <= '0;
      esel_q     <= '0;
      en_q       <= '0;
      ie_q       <= '0;
      ovf_q      <= '0;
      rdata_q    <= '0;
      perf_int_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      esel_q     <= esel_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
      perf_int_q <= perf_int_d;
    end
  end

  assign CRDDATA_R  = rdata_q;
  assign PERF_INT_R = perf_int_q;

endmodule
